// File: rtl/gray_codec_pipe.sv
// gray_codec_pipe: per-word binary<->Gray converter with a valid/ready pipeline.
// Latency: STAGES cycles from input transfer to out_valid; one word per cycle.
// Backpressure: a stage refills only when it is empty or its successor drains,
//   so in_ready is combinational from out_ready and holes in the pipe collapse.
//
// Parameters: WIDTH (2..32) data width, STAGES (1..WIDTH) register stages.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      input handshake; in_data word, in_mode 0=bin->Gray 1=Gray->bin
//   out_valid/out_ready    output handshake; out_data result, out_mode echoes in_mode
//   out_step_err           mode-1 word differs from the previous mode-1 word in >1 bit
// Optional: define GRAY_STEP_CHECK_EN to build the step checker; otherwise
//   out_step_err is always 0.
module gray_codec_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode,
  output logic             out_step_err
);

  // Gray-to-binary prefix XOR is resolved MSB-first, CHUNK bits per stage.
  localparam int CHUNK = (WIDTH + STAGES - 1) / STAGES;

  // Resolve the bits owned by one stage. Bits above the chunk are already
  // binary, bits below are still Gray, so each bit folds in its finished
  // upper neighbour.
  function automatic logic [WIDTH-1:0] f_g2b_chunk(input logic [WIDTH-1:0] word,
                                                   input int stage);
    logic [WIDTH-1:0] res;
    int hi;
    int lo;
    res = word;
    hi  = WIDTH - 1 - stage * CHUNK;
    lo  = WIDTH - (stage + 1) * CHUNK;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      if (i <= hi && i >= lo) res[i] = res[i] ^ res[i+1];
    end
    return res;
  endfunction

  logic [STAGES-1:0] r_vld;
  logic [STAGES-1:0] r_mode;
  logic [STAGES-1:0] r_err;
  logic [WIDTH-1:0]  r_dat [STAGES];
  logic [STAGES-1:0] w_ld;
  logic [WIDTH-1:0]  w_nxt [STAGES];
  logic              w_err_in;

  genvar gk;
  generate
    for (gk = 0; gk < STAGES; gk++) begin : g_stage
      // A stage may load if out_ready is high or any stage from here to the
      // output is empty (an empty slot downstream lets everything shift).
      assign w_ld[gk] = out_ready | ~(&r_vld[STAGES-1:gk]);
      if (gk == 0) begin : g_first
        // Binary-to-Gray completes here; later stages only carry the result.
        assign w_nxt[gk] = in_mode ? f_g2b_chunk(in_data, 0)
                                   : (in_data ^ (in_data >> 1));
      end else begin : g_rest
        assign w_nxt[gk] = r_mode[gk-1] ? f_g2b_chunk(r_dat[gk-1], gk)
                                        : r_dat[gk-1];
      end
    end
  endgenerate

  assign in_ready = w_ld[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= '0;
      r_mode <= '0;
      r_err  <= '0;
      for (int k = 0; k < STAGES; k++) r_dat[k] <= '0;
    end else begin
      if (w_ld[0]) begin
        r_vld[0]  <= in_valid;
        r_dat[0]  <= w_nxt[0];
        r_mode[0] <= in_mode;
        r_err[0]  <= w_err_in;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (w_ld[k]) begin
          r_vld[k]  <= r_vld[k-1];
          r_dat[k]  <= w_nxt[k];
          r_mode[k] <= r_mode[k-1];
          r_err[k]  <= r_err[k-1];
        end
      end
    end
  end

`ifdef GRAY_STEP_CHECK_EN
  logic [WIDTH-1:0] r_ref;
  logic             r_ref_vld;
  logic [WIDTH-1:0] w_diff;
  logic             w_in_xfer;

  assign w_in_xfer = in_valid & in_ready;
  assign w_diff    = in_data ^ r_ref;
  // Clearing the lowest set bit leaves a nonzero value exactly when two or
  // more bits differ.
  assign w_err_in  = in_mode & r_ref_vld & ((w_diff & (w_diff - WIDTH'(1))) != '0);

  // A mode-0 word breaks the Gray sequence, so it invalidates the reference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref     <= '0;
      r_ref_vld <= 1'b0;
    end else if (w_in_xfer) begin
      if (in_mode) begin
        r_ref     <= in_data;
        r_ref_vld <= 1'b1;
      end else begin
        r_ref_vld <= 1'b0;
      end
    end
  end
`else
  assign w_err_in = 1'b0;
`endif

  assign out_valid    = r_vld[STAGES-1];
  assign out_data     = r_dat[STAGES-1];
  assign out_mode     = r_mode[STAGES-1];
  assign out_step_err = r_err[STAGES-1];

endmodule
